// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared defaults, slice-width derivation and configuration check for pipelined_adder
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal only when the width splits into equal, non-empty slices.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational W-bit ripple add with carry-in and carry-out
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-slice pipelined adder/subtractor with valid/ready handshakes
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic advance;
  logic load;

  // A stall freezes every stage; bubbles are not squeezed out.
  assign advance  = !out_valid || out_ready;
  assign in_ready = rst_n && advance;
  assign load     = in_valid && in_ready;

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still pending at this stage: this slice plus all higher ones.
    localparam int OW = WIDTH - k * SW;

    logic [OW-1:0]       a_in;
    logic [OW-1:0]       b_in;
    logic                c_in;
    logic                v_in;
    logic [SW-1:0]       s_sl;
    logic                c_sl;
    logic [(k+1)*SW-1:0] s_next;
    logic [(k+1)*SW-1:0] s_q;
    logic                c_q;
    logic                v_q;

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = b ^ {WIDTH{sub}};
      assign c_in   = cin;
      assign v_in   = load;
      assign s_next = s_sl;
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {s_sl, g_stage[k-1].s_q};
    end

    adder_slice #(.W(SW)) u_slice (
      .a    (a_in[SW-1:0]),
      .b    (b_in[SW-1:0]),
      .cin  (c_in),
      .sum  (s_sl),
      .cout (c_sl)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_in;
        s_q <= s_next;
        c_q <= c_sl;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OW-SW-1:0] a_q;
      logic [OW-SW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_in[OW-1:SW];
          b_q <= b_in[OW-1:SW];
        end
      end
    end

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_next;
      // a^b^s at the MSB recovers the carry into the MSB.
      assign ovf_next = a_in[SW-1] ^ b_in[SW-1] ^ s_sl[SW-1] ^ c_sl;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_next;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;

endmodule
